// File: rtl/counter_mod_n.sv
// counter_mod_n: modulo-MOD up/down counter driven by raw active-low push-buttons.
// Per button: 2-flop synchroniser, debouncer and (up/down only) hold-to-repeat.
// The count wraps in both directions with one-cycle wrap pulses, and the value
// is shown on DIGITS seven-segment digits with leading zeros.
module counter_mod_n #(
  parameter int unsigned MOD        = 10,
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DIGITS     = 1,
  parameter int unsigned PRESET     = 5,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned REP_DELAY  = 25000000,
  parameter int unsigned REP_PERIOD = 5000000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [2:0]            i_Push,
  output logic [WIDTH-1:0]      o_Cnt,
  output logic [1:0]            o_Wrap,
  output logic [7*DIGITS-1:0]   o_FND
);

  localparam int unsigned DW      = $clog2(DEB_CYCLES + 1);
  localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned RW      = $clog2(REP_MAX + 1);
  localparam int unsigned CW      = WIDTH + 1;
  localparam int unsigned VW      = WIDTH + 4;
  localparam bit          REP_EN  = (REP_DELAY != 0);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'((REP_DELAY == 0) ? 0 : REP_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REP_PERIOD - 1);
  localparam logic [CW-1:0] TOP         = CW'(MOD - 1);

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [2:0]    press;
  logic [DW-1:0] deb_cnt [3];

  logic [RW-1:0] hold [2];
  logic [1:0]    first;
  logic [1:0]    rep;

  logic          ev_up;
  logic          ev_dn;
  logic          ev_pr;
  logic [CW-1:0] cnt_ext;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] cnt_dec;

  logic [VW-1:0] rem;
  logic [3:0]    digit;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
  endfunction

  // Synchronise buttons and debounce; press is a registered 1-cycle pulse on debounced 1->0
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      press <= '0;
      for (int unsigned j = 0; j < 3; j++) deb_cnt[j] <= '0;
    end else begin
      sync1 <= i_Push;
      sync2 <= sync1;
      press <= '0;
      for (int unsigned j = 0; j < 3; j++) begin
        if (sync2[j] == deb[j]) begin
          deb_cnt[j] <= '0;
        end else if (deb_cnt[j] == DEB_LAST) begin
          deb[j]     <= sync2[j];
          deb_cnt[j] <= '0;
          press[j]   <= ~sync2[j];
        end else begin
          deb_cnt[j] <= deb_cnt[j] + 1'b1;
        end
      end
    end
  end

  // Hold-to-repeat for up/down: counter restarts on the edge the debounced level falls,
  // so the first repeat lands REP_DELAY cycles after the press event, later ones every REP_PERIOD
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      first <= '1;
      rep   <= '0;
      for (int unsigned j = 0; j < 2; j++) hold[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < 2; j++) begin
        rep[j] <= 1'b0;
        if (!REP_EN || deb[j]) begin
          hold[j]  <= '0;
          first[j] <= 1'b1;
        end else if (hold[j] == (first[j] ? DELAY_LAST : PERIOD_LAST)) begin
          rep[j]   <= 1'b1;
          hold[j]  <= '0;
          first[j] <= 1'b0;
        end else begin
          hold[j] <= hold[j] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ev_up   = press[0] | rep[0];
    ev_dn   = press[1] | rep[1];
    ev_pr   = press[2];
    cnt_ext = {1'b0, o_Cnt};
    cnt_inc = cnt_ext + 1'b1;
    cnt_dec = cnt_ext - 1'b1;
  end

  // Count register with priority up > down > preset and registered wrap pulses
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      o_Cnt  <= '0;
      o_Wrap <= '0;
    end else begin
      o_Wrap <= '0;
      if (ev_up) begin
        if (cnt_ext == TOP) begin
          o_Cnt  <= '0;
          o_Wrap <= 2'b01;
        end else begin
          o_Cnt <= cnt_inc[WIDTH-1:0];
        end
      end else if (ev_dn) begin
        if (cnt_ext == '0) begin
          o_Cnt  <= TOP[WIDTH-1:0];
          o_Wrap <= 2'b10;
        end else begin
          o_Cnt <= cnt_dec[WIDTH-1:0];
        end
      end else if (ev_pr) begin
        o_Cnt <= WIDTH'(PRESET);
      end
    end
  end

  // Binary to decimal digits by repeated divide-by-ten, then segment decode
  always_comb begin
    rem   = VW'(o_Cnt);
    digit = '0;
    o_FND = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      digit            = 4'(rem % VW'(10));
      o_FND[7*k +: 7]  = seg(digit);
      rem              = rem / VW'(10);
    end
  end

endmodule

// File: tb/tb_counter_mod_n.sv
// Scoreboard bench for counter_mod_n: three instances (base, no auto-repeat,
// two-digit MOD=100). Stimulus pushes expected count changes with their cycle;
// a negedge monitor pops and compares whenever an instance's count changes.
module tb_counter_mod_n;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S6 = 7'b1111101;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1101111;

  typedef struct {
    int          inst;
    int          cyc;
    logic [6:0]  cnt;
    logic [1:0]  wrap;
    logic [13:0] fnd;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst;
  logic [2:0]  push [3];
  logic [3:0]  cnt0, cnt1;
  logic [6:0]  cnt2;
  logic [1:0]  wrap0, wrap1, wrap2;
  logic [6:0]  fnd0, fnd1;
  logic [13:0] fnd2;

  logic [6:0]  mcnt  [3];
  logic [1:0]  mwrap [3];
  logic [13:0] mfnd  [3];
  logic [6:0]  prev_cnt [3];

  exp_t sb[$];
  exp_t e_cur;
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;
  bit   mon_en = 1'b0;
  int   c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  counter_mod_n #(.MOD(10), .WIDTH(4), .DIGITS(1), .PRESET(5), .DEB_CYCLES(4),
                  .REP_DELAY(20), .REP_PERIOD(5)) u0 (
    .i_Clk(clk), .i_Rst(rst[0]), .i_Push(push[0]),
    .o_Cnt(cnt0), .o_Wrap(wrap0), .o_FND(fnd0));

  counter_mod_n #(.MOD(10), .WIDTH(4), .DIGITS(1), .PRESET(5), .DEB_CYCLES(4),
                  .REP_DELAY(0), .REP_PERIOD(5)) u1 (
    .i_Clk(clk), .i_Rst(rst[1]), .i_Push(push[1]),
    .o_Cnt(cnt1), .o_Wrap(wrap1), .o_FND(fnd1));

  counter_mod_n #(.MOD(100), .WIDTH(7), .DIGITS(2), .PRESET(37), .DEB_CYCLES(4),
                  .REP_DELAY(20), .REP_PERIOD(5)) u2 (
    .i_Clk(clk), .i_Rst(rst[2]), .i_Push(push[2]),
    .o_Cnt(cnt2), .o_Wrap(wrap2), .o_FND(fnd2));

  always_comb begin
    mcnt[0]  = {3'b000, cnt0};
    mcnt[1]  = {3'b000, cnt1};
    mcnt[2]  = cnt2;
    mwrap[0] = wrap0;
    mwrap[1] = wrap1;
    mwrap[2] = wrap2;
    mfnd[0]  = {7'b0, fnd0};
    mfnd[1]  = {7'b0, fnd1};
    mfnd[2]  = fnd2;
  end

  task automatic chk(input string name, input int inst, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s inst%0d @cyc %0d: got %0h expected %0h", name, inst, cyc, act, exp);
  endtask

  // Monitor: any count change pops the scoreboard; otherwise wrap must be idle
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        if (mcnt[i] !== prev_cnt[i]) begin
          if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_change inst%0d @cyc %0d: got %0d expected no change",
                     i, cyc, mcnt[i]);
          end else begin
            e_cur = sb.pop_front();
            chk("inst", i, i, e_cur.inst);
            chk("cycle", i, cyc, e_cur.cyc);
            chk("cnt", i, int'(mcnt[i]), int'(e_cur.cnt));
            chk("wrap", i, int'(mwrap[i]), int'(e_cur.wrap));
            chk("fnd", i, int'(mfnd[i]), int'(e_cur.fnd));
          end
        end else begin
          chk("wrap_idle", i, int'(mwrap[i]), 0);
        end
      end
      if (sb.size() != 0 && sb[0].cyc < cyc) begin
        e_cur = sb.pop_front();
        total++;
        $display("FAIL missing_event inst%0d: got no change by cyc %0d expected cnt %0d at cyc %0d",
                 e_cur.inst, cyc, e_cur.cnt, e_cur.cyc);
      end
    end
    for (int i = 0; i < 3; i++) prev_cnt[i] = mcnt[i];
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int inst, input int at, input logic [6:0] cv,
                           input logic [1:0] wv, input logic [13:0] fv);
    exp_t e;
    e.inst = inst; e.cyc = at; e.cnt = cv; e.wrap = wv; e.fnd = fv;
    sb.push_back(e);
  endtask

  // Clean press: event lands 6 edges after the first sampling edge
  task automatic press(input int inst, input int b, input int hold, input logic [6:0] cv,
                       input logic [1:0] wv, input logic [13:0] fv);
    expect_ev(inst, cyc + 7, cv, wv, fv);
    push[inst][b] = 1'b0;
    tick(hold);
    push[inst][b] = 1'b1;
    tick(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 3'b000;
    for (int i = 0; i < 3; i++) push[i] = 3'b111;
    tick(3);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cnt", i, int'(mcnt[i]), 0);
      chk("rst_wrap", i, int'(mwrap[i]), 0);
      chk("rst_fnd", i, int'(mfnd[i]), int'({7'b0, S0}));
    end
    chk("rst_cnt", 2, int'(mcnt[2]), 0);
    chk("rst_wrap", 2, int'(mwrap[2]), 0);
    chk("rst_fnd", 2, int'(mfnd[2]), int'({S0, S0}));
    mon_en = 1'b1;
    rst = 3'b111;
    tick(3);

    // Single press, then walk to 9 and wrap both ways
    press(0, 0, 8, 7'd1, 2'b00, {7'b0, S1});
    press(0, 2, 8, 7'd5, 2'b00, {7'b0, S5});
    press(0, 0, 8, 7'd6, 2'b00, {7'b0, S6});
    press(0, 0, 8, 7'd7, 2'b00, {7'b0, S7});
    press(0, 0, 8, 7'd8, 2'b00, {7'b0, S8});
    press(0, 0, 8, 7'd9, 2'b00, {7'b0, S9});
    press(0, 0, 8, 7'd0, 2'b01, {7'b0, S0});
    press(0, 1, 8, 7'd9, 2'b10, {7'b0, S9});

    // Bounce: short lows must not count; steady low counts once
    for (int k = 0; k < 3; k++) begin
      push[0][0] = 1'b0; tick(2);
      push[0][0] = 1'b1; tick(2);
    end
    press(0, 0, 10, 7'd0, 2'b01, {7'b0, S0});

    // Hold down from 5 with auto-repeat
    press(0, 2, 8, 7'd5, 2'b00, {7'b0, S5});
    c = cyc;
    expect_ev(0, c + 7,  7'd4, 2'b00, {7'b0, S4});
    expect_ev(0, c + 27, 7'd3, 2'b00, {7'b0, S3});
    expect_ev(0, c + 32, 7'd2, 2'b00, {7'b0, 7'b1011011});
    expect_ev(0, c + 37, 7'd1, 2'b00, {7'b0, S1});
    expect_ev(0, c + 42, 7'd0, 2'b00, {7'b0, S0});
    expect_ev(0, c + 47, 7'd9, 2'b10, {7'b0, S9});
    push[0][1] = 1'b0;
    tick(42);
    push[0][1] = 1'b1;
    tick(14);

    // Same hold with auto-repeat disabled
    press(1, 2, 8, 7'd5, 2'b00, {7'b0, S5});
    press(1, 1, 42, 7'd4, 2'b00, {7'b0, S4});

    // Priority: up and preset together at 2
    press(0, 0, 8, 7'd0, 2'b01, {7'b0, S0});
    press(0, 0, 8, 7'd1, 2'b00, {7'b0, S1});
    press(0, 0, 8, 7'd2, 2'b00, {7'b0, 7'b1011011});
    expect_ev(0, cyc + 7, 7'd3, 2'b00, {7'b0, S3});
    push[0] = 3'b010;
    tick(8);
    push[0] = 3'b111;
    tick(10);
    press(0, 2, 40, 7'd5, 2'b00, {7'b0, S5});

    // Two-digit instance: wraps, preset display, reset mid-debounce
    press(2, 1, 8, 7'd99, 2'b10, {S9, S9});
    press(2, 0, 8, 7'd0,  2'b01, {S0, S0});
    press(2, 2, 8, 7'd37, 2'b00, {S3, S7});
    push[2][0] = 1'b0;
    tick(3);
    rst[2] = 1'b0;
    expect_ev(2, cyc + 1, 7'd0, 2'b00, {S0, S0});
    tick(2);
    push[2][0] = 1'b1;
    tick(1);
    rst[2] = 1'b1;
    tick(15);

    chk("sb_empty", 0, sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
